pipeline_skid_bp_if: RTL and testbench
======================================

Name: pipeline_skid_bp_if

Overview:
- Fully registered AXI-stream pipeline stage. Registers both the forward path (dat/val/sop/eop/err/mod/ctl) and the backward rdy path using a 2-entry skid buffer.
- Complements the forward-only pipeline stages. Inserted where the rdy path, not the data path, limits timing, e.g. long return routes between MSM/NTT cores and the host stream.
- Optional LFSR-driven random backpressure on the input side and random valid hold-off on the output side, for verification.

Parameters:
- DAT_BYTS, 8, data width in bytes.
- DAT_BITS, DAT_BYTS*8, data width in bits.
- CTL_BITS, 8, width of the ctl sideband.
- RANDOM_BP, 0, 1 enables random i_if.rdy deassertion and random o_if.val hold-off.
- LFSR_SEED, 16'hACE1, non-zero reset value of the 16-bit LFSR.

Ports:
- i_clk  input  1  single clock; all state on rising edge.
- i_rst  input  1  asynchronous, active-low reset.
- i_if  if_axi_stream (sink side)  DAT_BITS/CTL_BITS  upstream stream. Fields dat, val, sop, eop, err, mod, ctl are inputs; rdy is an output.
- o_if  if_axi_stream (source side)  DAT_BITS/CTL_BITS  downstream stream. Fields dat, val, sop, eop, err, mod, ctl are outputs; rdy is an input.

Behaviour:
- **Storage:**
  - main register M drives o_if.
  - skid register S holds one beat captured while o_if.rdy was low.
  - Each register holds dat, sop, eop, err, mod, ctl and a valid flag.
- **Reset (i_rst=0, async):**
  - M.val=0, S.val=0, i_if.rdy=0, o_if.val=0.
  - o_if.dat/sop/eop/err/mod/ctl=0; LFSR=LFSR_SEED; hold-off flag=0.
  - First cycle after release: i_if.rdy=1, unless RANDOM_BP masks it.
- **Handshakes:**
  - Input transfer: i_if.val & i_if.rdy.
  - Output transfer: o_if.val & o_if.rdy.
- **i_if.rdy is a flop output:**
  - base value is ~S.val of the next state.
  - with RANDOM_BP=1 it is additionally forced 0 when LFSR[1:0]==2'b00.
  - No combinational path from o_if.rdy to i_if.rdy.
- **Latency:** 1 cycle from input transfer to o_if.val, when M is empty or draining.
- **Next-state rules** (evaluated every cycle):
  - M empty or output transfer, S empty: M loads the input beat if there is an input transfer, else M.val clears on output transfer.
  - M empty or output transfer, S full: M loads S, S clears. An input transfer cannot occur, because rdy was low.
  - M full and no output transfer, input transfer: beat goes to S, and next i_if.rdy=0.
- **Ordering and integrity:**
  - Beat order is preserved.
  - No beat is dropped or duplicated.
  - sop/eop/err/mod/ctl travel with their dat unchanged.
- **Throughput:** full rate (1 beat/cycle) with o_if.rdy held 1 and RANDOM_BP=0.
- **Simultaneous events:**
  - Input and output transfer in the same cycle with S empty: M replaced, S stays empty.
  - Output transfer while S full: S moves to M, and rdy reasserts the next cycle.
- **Random valid hold-off (RANDOM_BP=1):**
  - When M loads a new beat, hold-off flag = (LFSR[3:2]==2'b00).
  - While the flag is set, o_if.val=0; the flag clears the next cycle.
  - Once o_if.val rises, it stays high with stable fields until the output transfer. No valid retraction.
- **LFSR:**
  - 16-bit Galois, taps 16,14,13,11, advances every cycle.
  - Held at seed when RANDOM_BP=0; logic optimised away.
- **Reset mid-packet:** all beats held in M/S are discarded; outputs return immediately to reset values.

Decomposition:
- Package pipeline_bp_pkg:
  - typedef of the beat record (dat, sop, eop, err, mod, ctl) parameterised via localparams.
  - LFSR tap constant and default seed.
- Sub-module lfsr16: free-running Galois LFSR with seed and enable inputs. Instantiated only when RANDOM_BP=1.

Test Plan:
- **Continuous flow:** 64 beats dat=0..63, val always 1, o_if.rdy always 1 → o_if shows 0..63 on consecutive cycles, first beat 1 cycle after its input transfer, i_if.rdy constantly 1.
- **Single stall:** o_if.rdy=0 for 1 cycle mid-stream at beat 10 → beat 11 captured in S, i_if.rdy=0 the next cycle, output resumes 10,11,12 with no gaps or duplicates.
- **Long stall:** o_if.rdy=0 for 20 cycles → exactly 2 beats buffered, i_if.rdy low the whole stall, o_if.dat stable throughout, correct order on release.
- **Sideband:** 3 packets of lengths 1, 5, 8 beats with ctl=8'h5A, err set on last beat of packet 2, mod=3 on eop → identical sop/eop/err/mod/ctl at output.
- **RANDOM_BP=1** with random o_if.rdy, 10k beats of incrementing data → scoreboard matches in order, no valid retraction (assertion), throughput <100%.
- **Async reset:** i_rst pulsed low mid-packet with M and S full → o_if.val and i_if.rdy go 0 immediately; after release, a fresh 4-beat packet passes unchanged.

Source files
------------

// File: rtl/pipeline_skid_bp_if_pkg.sv
// Shared types and constants for the skid-buffered
// backpressure stage: beat record, LFSR taps, seed.
package pipeline_bp_pkg;

  function automatic int mod_bits(input int byts);
    return (byts > 1) ? $clog2(byts) : 1;
  endfunction

  localparam int DAT_BYTS_D = 8;
  localparam int DAT_BITS_D = DAT_BYTS_D * 8;
  localparam int CTL_BITS_D = 8;
  localparam int MOD_BITS_D = mod_bits(DAT_BYTS_D);

  // Galois taps 16,14,13,11 for a right-shifting register
  localparam logic [15:0] LFSR_TAPS   = 16'hB400;
  localparam logic [15:0] LFSR_SEED_D = 16'hACE1;

  typedef struct packed {
    logic [DAT_BITS_D-1:0] dat;
    logic                  sop;
    logic                  eop;
    logic                  err;
    logic [MOD_BITS_D-1:0] mod;
    logic [CTL_BITS_D-1:0] ctl;
  } beat_t;

  function automatic logic [15:0] lfsr_step(
    input logic [15:0] s
  );
    return (s >> 1) ^ (s[0] ? LFSR_TAPS : 16'h0000);
  endfunction

endpackage

// File: rtl/pipeline_skid_bp_if_if.sv
// AXI-stream style bundle: data, sidebands and
// valid/ready handshake, with source/sink modports.
interface if_axi_stream
  import pipeline_bp_pkg::*;
#(
  parameter int DAT_BITS = DAT_BITS_D,
  parameter int CTL_BITS = CTL_BITS_D,
  parameter int MOD_BITS = MOD_BITS_D
);
  logic [DAT_BITS-1:0] dat;
  logic                val;
  logic                sop;
  logic                eop;
  logic                err;
  logic [MOD_BITS-1:0] mod;
  logic [CTL_BITS-1:0] ctl;
  logic                rdy;

  modport master (
    output dat, val, sop, eop, err, mod, ctl,
    input  rdy
  );

  modport slave (
    input  dat, val, sop, eop, err, mod, ctl,
    output rdy
  );
endinterface

// File: rtl/pipeline_skid_bp_if_lfsr16.sv
// Free-running 16-bit Galois LFSR, loads its seed
// on reset and steps whenever enabled.
module lfsr16
  import pipeline_bp_pkg::*;
#(
  parameter int OUT_W = 16
)(
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_en,
  input  logic [15:0]      i_seed,
  output logic [OUT_W-1:0] o_lfsr
);

  logic [15:0] r_lfsr;

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_lfsr <= i_seed;
    end else if (i_en) begin
      r_lfsr <= lfsr_step(r_lfsr);
    end
  end

  assign o_lfsr = r_lfsr[OUT_W-1:0];

endmodule

// File: rtl/pipeline_skid_bp_if.sv
// Fully registered stream stage: main register M feeds
// o_if, skid register S absorbs one beat under stall.
module pipeline_skid_bp_if
  import pipeline_bp_pkg::*;
#(
  parameter int          DAT_BYTS  = DAT_BYTS_D,
  parameter int          DAT_BITS  = DAT_BYTS * 8,
  parameter int          CTL_BITS  = CTL_BITS_D,
  parameter int          RANDOM_BP = 0,
  parameter logic [15:0] LFSR_SEED = LFSR_SEED_D
)(
  input logic          i_clk,
  input logic          i_rst,
  if_axi_stream.slave  i_if,
  if_axi_stream.master o_if
);

  localparam int MOD_BITS = mod_bits(DAT_BYTS);

  typedef struct packed {
    logic [DAT_BITS-1:0] dat;
    logic                sop;
    logic                eop;
    logic                err;
    logic [MOD_BITS-1:0] mod;
    logic [CTL_BITS-1:0] ctl;
  } bt_t;

  bt_t  r_m;
  bt_t  r_s;
  logic r_m_val;
  logic r_s_val;
  logic r_rdy;
  logic r_hold;

  bt_t  w_in;
  bt_t  w_m_nxt;
  bt_t  w_s_nxt;
  logic w_m_val_nxt;
  logic w_s_val_nxt;
  logic w_load;
  logic w_rdy_nxt;
  logic w_hold_nxt;
  logic w_o_val;
  logic w_in_xfer;
  logic w_out_xfer;
  logic w_m_free;
  logic w_bp_mask;
  logic w_ho_roll;
  logic [3:0] w_rnd;

  generate
    if (RANDOM_BP != 0) begin : g_lfsr
      lfsr16 #(
        .OUT_W (4)
      ) u_lfsr (
        .i_clk  (i_clk),
        .i_rst  (i_rst),
        .i_en   (1'b1),
        .i_seed (LFSR_SEED),
        .o_lfsr (w_rnd)
      );
    end else begin : g_no_lfsr
      assign w_rnd = LFSR_SEED[3:0];
    end
  endgenerate

  assign w_bp_mask = (RANDOM_BP != 0)
                   && (w_rnd[1:0] == 2'b00);
  assign w_ho_roll = (RANDOM_BP != 0)
                   && (w_rnd[3:2] == 2'b00);

  always_comb begin
    w_in.dat = i_if.dat;
    w_in.sop = i_if.sop;
    w_in.eop = i_if.eop;
    w_in.err = i_if.err;
    w_in.mod = i_if.mod;
    w_in.ctl = i_if.ctl;
  end

  // A held-off beat is invisible downstream, so it
  // cannot transfer and M counts as occupied.
  assign w_o_val    = r_m_val & ~r_hold;
  assign w_in_xfer  = i_if.val & r_rdy;
  assign w_out_xfer = w_o_val & o_if.rdy;
  assign w_m_free   = ~r_m_val | w_out_xfer;

  always_comb begin
    w_m_nxt     = r_m;
    w_s_nxt     = r_s;
    w_m_val_nxt = r_m_val;
    w_s_val_nxt = r_s_val;
    w_load      = 1'b0;
    unique case (1'b1)
      w_m_free & r_s_val: begin
        w_m_nxt     = r_s;
        w_m_val_nxt = 1'b1;
        w_s_val_nxt = 1'b0;
        w_load      = 1'b1;
      end
      w_m_free & ~r_s_val & w_in_xfer: begin
        w_m_nxt     = w_in;
        w_m_val_nxt = 1'b1;
        w_load      = 1'b1;
      end
      w_m_free & ~r_s_val & ~w_in_xfer: begin
        w_m_val_nxt = 1'b0;
      end
      ~w_m_free & w_in_xfer: begin
        w_s_nxt     = w_in;
        w_s_val_nxt = 1'b1;
      end
      default: begin
      end
    endcase
  end

  // rdy is decided from next-state only, so o_if.rdy
  // never reaches i_if.rdy combinationally.
  assign w_rdy_nxt  = ~w_s_val_nxt & ~w_bp_mask;
  assign w_hold_nxt = w_load & w_ho_roll;

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_m     <= '0;
      r_s     <= '0;
      r_m_val <= 1'b0;
      r_s_val <= 1'b0;
      r_rdy   <= 1'b0;
      r_hold  <= 1'b0;
    end else begin
      r_m     <= w_m_nxt;
      r_s     <= w_s_nxt;
      r_m_val <= w_m_val_nxt;
      r_s_val <= w_s_val_nxt;
      r_rdy   <= w_rdy_nxt;
      r_hold  <= w_hold_nxt;
    end
  end

  assign i_if.rdy = r_rdy;

  assign o_if.val = w_o_val;
  assign o_if.dat = r_m.dat;
  assign o_if.sop = r_m.sop;
  assign o_if.eop = r_m.eop;
  assign o_if.err = r_m.err;
  assign o_if.mod = r_m.mod;
  assign o_if.ctl = r_m.ctl;

endmodule

// File: tb/tb_pipeline_skid_bp_if.sv
// Bench for pipeline_skid_bp_if: a plain stage and a
// random-backpressure stage against queue models.
module tb_pipeline_skid_bp_if;
  import pipeline_bp_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  if_axi_stream a_i ();
  if_axi_stream a_o ();
  if_axi_stream b_i ();
  if_axi_stream b_o ();

  pipeline_skid_bp_if #(.RANDOM_BP(0)) dut0 (
    .i_clk (clk),
    .i_rst (rst_n),
    .i_if  (a_i),
    .o_if  (a_o)
  );

  pipeline_skid_bp_if #(.RANDOM_BP(1)) dut1 (
    .i_clk (clk),
    .i_rst (rst_n),
    .i_if  (b_i),
    .o_if  (b_o)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm,
                     input logic [127:0] act,
                     input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h",
               nm, act, exp);
    end
  endtask

  // ---------- plain stage: depth-2 FIFO model ----------
  beat_t src_q[$];
  beat_t exp_q[$];
  int    exp_inc[$];
  beat_t log_b[$];
  int    log_cyc[$];
  int    log_inc[$];
  bit    exp_rdy;
  bit    mon_en = 0;
  int    rdy_low = 0;

  always @(negedge clk) begin
    beat_t ob;
    bit in_x, out_x;
    ob = '{dat: a_o.dat, sop: a_o.sop, eop: a_o.eop,
           err: a_o.err, mod: a_o.mod, ctl: a_o.ctl};
    if (!rst_n) begin
      chk("rst_oval", a_o.val, 0);
      chk("rst_irdy", a_i.rdy, 0);
      chk("rst_odat", a_o.dat, 0);
      exp_q.delete();
      exp_inc.delete();
      exp_rdy = 1'b1;
    end else begin
      chk("irdy", a_i.rdy, exp_rdy);
      chk("oval", a_o.val, exp_q.size() > 0);
      if (exp_q.size() > 0 && a_o.val)
        chk("obeat", 128'(ob), 128'(exp_q[0]));
      in_x  = a_i.val && exp_rdy;
      out_x = (exp_q.size() > 0) && a_o.rdy;
      if (out_x) begin
        log_b.push_back(exp_q[0]);
        log_cyc.push_back(cyc);
        log_inc.push_back(exp_inc[0]);
        void'(exp_q.pop_front());
        void'(exp_inc.pop_front());
      end
      if (in_x) begin
        exp_q.push_back('{dat: a_i.dat, sop: a_i.sop,
                          eop: a_i.eop, err: a_i.err,
                          mod: a_i.mod, ctl: a_i.ctl});
        exp_inc.push_back(cyc);
      end
      exp_rdy = exp_q.size() < 2;
    end
  end

  always @(negedge clk)
    if (rst_n && mon_en && !a_i.rdy)
      rdy_low <= rdy_low + 1;

  initial begin
    a_i.val = 0; a_i.dat = 0; a_i.sop = 0; a_i.eop = 0;
    a_i.err = 0; a_i.mod = 0; a_i.ctl = 0;
    forever begin
      @(negedge clk);
      if (rst_n && a_i.val && a_i.rdy && src_q.size() > 0)
        void'(src_q.pop_front());
      @(posedge clk);
      #1;
      if (src_q.size() > 0) begin
        a_i.val = 1;
        a_i.dat = src_q[0].dat;
        a_i.sop = src_q[0].sop;
        a_i.eop = src_q[0].eop;
        a_i.err = src_q[0].err;
        a_i.mod = src_q[0].mod;
        a_i.ctl = src_q[0].ctl;
      end else begin
        a_i.val = 0;
      end
    end
  end

  // ---------- random stage: scoreboard + properties ----------
  beat_t q1[$];
  int    rcv1 = 0;
  int    bp_seen = 0;
  int    ho_seen = 0;
  bit    r_active = 0;
  bit    pend_hold = 0;
  beat_t prev_b;

  always @(negedge clk) begin
    beat_t ob;
    ob = '{dat: b_o.dat, sop: b_o.sop, eop: b_o.eop,
           err: b_o.err, mod: b_o.mod, ctl: b_o.ctl};
    if (!rst_n) begin
      q1.delete();
      pend_hold = 0;
    end else begin
      if (b_o.val) begin
        chk("rnd_oval_nonempty", q1.size() > 0, 1);
        if (q1.size() > 0)
          chk("rnd_beat", 128'(ob), 128'(q1[0]));
      end
      if (pend_hold) begin
        chk("rnd_no_retract", b_o.val, 1);
        chk("rnd_stable", 128'(ob), 128'(prev_b));
      end
      if (b_i.rdy)
        chk("rnd_rdy_cap", q1.size() < 2, 1);
      if (r_active && !b_i.rdy && q1.size() < 2)
        bp_seen++;
      if (r_active && !b_o.val && q1.size() > 0)
        ho_seen++;
      pend_hold = b_o.val && !b_o.rdy;
      prev_b = ob;
      if (b_o.val && b_o.rdy) begin
        void'(q1.pop_front());
        rcv1++;
      end
      if (b_i.val && b_i.rdy)
        q1.push_back('{dat: b_i.dat, sop: b_i.sop,
                       eop: b_i.eop, err: b_i.err,
                       mod: b_i.mod, ctl: b_i.ctl});
    end
  end

  // ---------- helpers ----------
  function automatic beat_t mk(input logic [63:0] d,
                               input bit s, input bit e,
                               input bit r,
                               input logic [2:0] m,
                               input logic [7:0] c);
    beat_t b;
    b.dat = d; b.sop = s; b.eop = e;
    b.err = r; b.mod = m; b.ctl = c;
    return b;
  endfunction

  task automatic clear_log();
    log_b.delete();
    log_cyc.delete();
    log_inc.delete();
  endtask

  task automatic wait_log(input int n, input int budget);
    int k = 0;
    while (log_b.size() < n && k < budget) begin
      @(negedge clk);
      k++;
    end
    chk("log_count", log_b.size(), n);
  endtask

  task automatic wait_out(input logic [63:0] v,
                          input int budget);
    int k = 0;
    bit hit = 0;
    while (!hit && k < budget) begin
      @(posedge clk);
      #1;
      hit = a_o.val && (a_o.dat == v);
      k++;
    end
    chk("wait_out", hit, 1);
  endtask

  task automatic check_order(input string nm, input int n,
                             input logic [63:0] base);
    int bad = 0;
    if (log_b.size() != n) bad++;
    else
      for (int k = 0; k < n; k++)
        if (log_b[k].dat != base + 64'(k)) bad++;
    chk(nm, bad, 0);
  endtask

  task automatic drive_b(input int n);
    b_i.val = 1;
    b_i.dat = 64'(n);
    b_i.sop = (n % 8) == 0;
    b_i.eop = (n % 8) == 7;
    b_i.err = 0;
    b_i.mod = 3'(n);
    b_i.ctl = 8'(n);
  endtask

  initial begin
    #900000;
    errors++;
    $display("FAIL watchdog: got timeout expected finish");
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

  // ---------- main sequence ----------
  initial begin
    beat_t sb_exp[$];
    int lens[3];
    int n, k, nsend;
    bit acc;

    rst_n = 1;
    a_o.rdy = 0;
    b_o.rdy = 0;
    b_i.val = 0; b_i.dat = 0; b_i.sop = 0; b_i.eop = 0;
    b_i.err = 0; b_i.mod = 0; b_i.ctl = 0;
    #2 rst_n = 0;
    repeat (3) @(negedge clk);
    #1 rst_n = 1;
    @(posedge clk);
    #1;
    chk("rdy_after_rst", a_i.rdy, 1);
    chk("oval_after_rst", a_o.val, 0);

    // continuous flow
    a_o.rdy = 1;
    clear_log();
    rdy_low = 0;
    mon_en = 1;
    for (int i = 0; i < 64; i++)
      src_q.push_back(mk(64'(i), i == 0, i == 63, 0, 0, 0));
    wait_log(64, 200);
    mon_en = 0;
    check_order("flow_order", 64, 0);
    if (log_b.size() == 64) begin
      chk("flow_gapless", log_cyc[63] - log_cyc[0], 63);
      chk("flow_latency", log_cyc[0] - log_inc[0], 1);
    end
    chk("flow_rdy_low", rdy_low, 0);

    // single stall
    @(posedge clk);
    #1;
    clear_log();
    for (int i = 0; i < 30; i++)
      src_q.push_back(mk(64'(i), i == 0, i == 29, 0, 0, 8'h11));
    wait_out(10, 100);
    a_o.rdy = 0;
    @(posedge clk);
    #1;
    chk("stall1_irdy", a_i.rdy, 0);
    chk("stall1_hold", a_o.dat, 10);
    a_o.rdy = 1;
    wait_log(30, 200);
    check_order("stall1_order", 30, 0);
    if (log_b.size() == 30)
      chk("stall1_gapless", log_cyc[12] - log_cyc[10], 2);

    // long stall
    @(posedge clk);
    #1;
    clear_log();
    for (int i = 0; i < 40; i++)
      src_q.push_back(mk(64'(i), i == 0, i == 39, 0, 0, 8'h22));
    wait_out(10, 100);
    a_o.rdy = 0;
    repeat (20) begin
      @(posedge clk);
      #1;
      chk("stall_irdy", a_i.rdy, 0);
      chk("stall_oval", a_o.val, 1);
      chk("stall_odat", a_o.dat, 10);
    end
    chk("stall_buffered", src_q.size() > 0 ? src_q[0].dat : 0, 12);
    a_o.rdy = 1;
    wait_log(40, 300);
    check_order("stall_order", 40, 0);

    // sideband packets with random output stalls
    @(posedge clk);
    #1;
    clear_log();
    lens = '{1, 5, 8};
    n = 0;
    for (int p = 0; p < 3; p++)
      for (int i = 0; i < lens[p]; i++) begin
        sb_exp.push_back(mk(64'hB000 + 64'(n), i == 0,
                            i == lens[p] - 1,
                            p == 1 && i == lens[p] - 1,
                            (i == lens[p] - 1) ? 3'd3 : 3'd0,
                            8'h5A));
        n++;
      end
    foreach (sb_exp[i]) src_q.push_back(sb_exp[i]);
    k = 0;
    while (log_b.size() < 14 && k < 300) begin
      @(posedge clk);
      #1;
      a_o.rdy = ($urandom % 3) != 0;
      k++;
    end
    a_o.rdy = 1;
    chk("sb_count", log_b.size(), 14);
    for (int i = 0; i < 14 && i < log_b.size(); i++)
      chk("sb_beat", 128'(log_b[i]), 128'(sb_exp[i]));
    if (log_b.size() == 14) begin
      chk("sb_err_pos", log_b[5].err, 1);
      chk("sb_eop_pos", log_b[5].eop, 1);
      chk("sb_mod_eop", log_b[13].mod, 3);
      chk("sb_ctl", log_b[7].ctl, 8'h5A);
    end

    // async reset with M and S full
    @(posedge clk);
    #1;
    clear_log();
    a_o.rdy = 0;
    for (int i = 0; i < 10; i++)
      src_q.push_back(mk(64'hC000 + 64'(i), i == 0, 0, 0, 0, 0));
    k = 0;
    acc = 0;
    while (!acc && k < 50) begin
      @(posedge clk);
      #1;
      acc = a_o.val && !a_i.rdy;
      k++;
    end
    chk("arst_full", acc, 1);
    #1 rst_n = 0;
    src_q.delete();
    #1;
    chk("arst_oval", a_o.val, 0);
    chk("arst_irdy", a_i.rdy, 0);
    chk("arst_odat", a_o.dat, 0);
    repeat (2) @(negedge clk);
    #1;
    rst_n = 1;
    a_o.rdy = 1;
    clear_log();
    for (int i = 0; i < 4; i++)
      src_q.push_back(mk(64'hD000 + 64'(i), i == 0, i == 3,
                         0, (i == 3) ? 3'd2 : 3'd0, 8'h33));
    wait_log(4, 50);
    check_order("arst_pkt", 4, 64'hD000);
    if (log_b.size() == 4) begin
      chk("arst_sop", log_b[0].sop, 1);
      chk("arst_eop", log_b[3].eop, 1);
      chk("arst_mod", log_b[3].mod, 2);
    end

    // random backpressure stage
    @(posedge clk);
    #1;
    nsend = 0;
    drive_b(nsend);
    b_o.rdy = ($urandom % 4) != 0;
    r_active = 1;
    k = 0;
    while (rcv1 < 10000 && k < 60000) begin
      @(negedge clk);
      acc = b_i.val && b_i.rdy;
      @(posedge clk);
      #1;
      if (acc) nsend++;
      drive_b(nsend);
      b_o.rdy = ($urandom % 4) != 0;
      k++;
    end
    r_active = 0;
    b_i.val = 0;
    b_o.rdy = 1;
    chk("rnd_count", rcv1, 10000);
    chk("rnd_tput_lt_full", k > 10000, 1);
    chk("rnd_bp_seen", bp_seen > 0, 1);
    chk("rnd_holdoff_seen", ho_seen > 0, 1);

    repeat (4) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
